// File: rtl/data_mem_ctl_pkg.sv
// Shared types and parameter checks for the data memory controller.
// Imported by the interface, the clear sequencer and the top.
package data_mem_ctl_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RD_LAT_COMB = 0;
  localparam int RD_LAT_REG  = 1;

  function automatic bit params_ok(input int w, input int a, input int depth, input int rd_lat);
    bit ok;
    ok = (w > 0) && (w % 8 == 0);
    ok = ok && (a > 0) && (a < 32);
    ok = ok && (depth >= 1) && (depth <= (1 << a));
    ok = ok && ((rd_lat == RD_LAT_COMB) || (rd_lat == RD_LAT_REG));
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_ctl_if.sv
// Request/response bus between the load/store unit (master) and the data memory (slave).
interface data_mem_ctl_if #(
  parameter int W = 8,
  parameter int A = 8
);

  // A request transfers on a rising clock edge where req_valid && req_ready. The master
  // keeps req_write/addr/wdata/wstrb stable while req_valid is high and unaccepted;
  // req_ready never depends on req_valid. rdata_valid and err are single-cycle pulses.
  logic           req_valid;
  logic           req_ready;
  logic           req_write;
  logic [A-1:0]   addr;
  logic [W-1:0]   wdata;
  logic [W/8-1:0] wstrb;
  logic [W-1:0]   rdata;
  logic           rdata_valid;
  logic           err;

  modport master (
    output req_valid, req_write, addr, wdata, wstrb,
    input  req_ready, rdata, rdata_valid, err
  );

  modport slave (
    input  req_valid, req_write, addr, wdata, wstrb,
    output req_ready, rdata, rdata_valid, err
  );

endinterface

// File: rtl/data_mem_ctl_clear_seq.sv
// Clear sweep sequencer: walks clr_ptr from 0 to DEPTH-1, one entry per cycle
// while run is high, and flags the cycle that writes the last entry.
module data_mem_ctl_clear_seq #(
  parameter int A     = 8,
  parameter int DEPTH = 2 ** A
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         run,
  output logic         clr_we,
  output logic [A-1:0] clr_addr,
  output logic         clr_done
);

  localparam logic [A-1:0] LAST = A'(DEPTH - 1);

  logic [A-1:0] clr_ptr_q;
  logic [A-1:0] clr_ptr_d;

  assign clr_we   = run;
  assign clr_addr = clr_ptr_q;
  assign clr_done = run && (clr_ptr_q == LAST);

  // Pointer parks at 0 after the last entry so a later start always begins cleanly.
  always_comb begin
    clr_ptr_d = clr_ptr_q;
    if (start || clr_done) begin
      clr_ptr_d = '0;
    end else if (run) begin
      clr_ptr_d = clr_ptr_q + A'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_ptr_q <= '0;
    end else begin
      clr_ptr_q <= clr_ptr_d;
    end
  end

endmodule

// File: rtl/data_mem_ctl.sv
// Single-port data memory behind the load/store unit: byte-lane stores, range-checked
// loads with 0- or 1-cycle latency, and a full clear sweep after reset or on clr_req.
module data_mem_ctl
  import data_mem_ctl_pkg::*;
#(
  parameter int           W       = 8,
  parameter int           A       = 8,
  parameter int           DEPTH   = 2 ** A,
  parameter int           RD_LAT  = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_req,
  output logic            busy,
  output state_t          dbg_state,
  data_mem_ctl_if.slave   bus
);

  localparam int NB = W / 8;

  if (!params_ok(W, A, DEPTH, RD_LAT)) begin : g_bad_params
    $error("data_mem_ctl: illegal parameter combination");
  end

  state_t state_q;
  state_t state_d;

  logic [W-1:0] core_q [DEPTH];

  logic         acc;
  logic         ld_acc;
  logic         st_acc;
  logic         in_range;
  logic         start;
  logic         clr_we;
  logic         clr_done;
  logic [A-1:0] clr_addr;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic [W-1:0] rd_word;

  assign bus.req_ready = (state_q == READY);
  assign busy          = (state_q == CLEAR);
  assign dbg_state     = state_q;

  assign acc      = bus.req_valid && bus.req_ready;
  assign ld_acc   = acc && !bus.req_write;
  assign st_acc   = acc && bus.req_write;
  assign in_range = (32'(bus.addr) < 32'(DEPTH));
  assign start    = (state_q == READY) && clr_req;
  assign rd_word  = in_range ? core_q[bus.addr] : '0;

  data_mem_ctl_clear_seq #(
    .A     (A),
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .run      (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_done (clr_done)
  );

  // An accepted request in the same cycle as clr_req still completes; CLEAR starts after.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_done) state_d = READY;
      READY:   if (clr_req)  state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Single write port: the sweep owns it in CLEAR, in-range stores own it in READY.
  // Unstrobed lanes are rewritten with their current contents.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.addr;
    wr_data = rd_word;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = CLR_VAL;
    end else if (st_acc && in_range) begin
      wr_en = 1'b1;
      for (int i = 0; i < NB; i++) begin
        if (bus.wstrb[i]) begin
          wr_data[8*i +: 8] = bus.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      core_q[wr_addr] <= wr_data;
    end
  end

  if (RD_LAT == RD_LAT_REG) begin : g_rd_reg
    logic [W-1:0] rdata_q;
    logic [W-1:0] rdata_d;
    logic         rvalid_q;
    logic         rvalid_d;
    logic         err_q;
    logic         err_d;

    // rdata keeps the last loaded word between loads.
    always_comb begin
      rdata_d  = ld_acc ? rd_word : rdata_q;
      rvalid_d = ld_acc;
      err_d    = acc && !in_range;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
        err_q    <= err_d;
      end
    end

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvalid_q;
    assign bus.err         = err_q;
  end else begin : g_rd_comb
    assign bus.rdata       = ld_acc ? rd_word : '0;
    assign bus.rdata_valid = ld_acc;
    assign bus.err         = acc && !in_range;
  end

endmodule

// File: tb/tb_data_mem_ctl.sv
// Two controllers on one request stream: A (DEPTH=200, registered reads, nonzero clear value)
// and B (DEPTH=256, combinational reads), both checked against a word-array model.
module tb_data_mem_ctl;
  import data_mem_ctl_pkg::*;

  localparam int           W       = 32;
  localparam int           A       = 8;
  localparam int           DEPTH_A = 200;
  localparam int           DEPTH_B = 256;
  localparam logic [W-1:0] CLR_A   = 32'h5EED_0A11;
  localparam logic [W-1:0] CLR_B   = 32'h0000_0000;

  logic         clk;
  logic         reset;
  logic         clr_req;
  logic         busy_a;
  logic         busy_b;
  state_t       state_a;
  state_t       state_b;
  logic         req_valid;
  logic         req_write;
  logic [A-1:0] addr;
  logic [W-1:0] wdata;
  logic [3:0]   wstrb;

  data_mem_ctl_if #(.W(W), .A(A)) if_a ();
  data_mem_ctl_if #(.W(W), .A(A)) if_b ();

  assign if_a.req_valid = req_valid;
  assign if_a.req_write = req_write;
  assign if_a.addr      = addr;
  assign if_a.wdata     = wdata;
  assign if_a.wstrb     = wstrb;
  assign if_b.req_valid = req_valid;
  assign if_b.req_write = req_write;
  assign if_b.addr      = addr;
  assign if_b.wdata     = wdata;
  assign if_b.wstrb     = wstrb;

  data_mem_ctl #(
    .W(W), .A(A), .DEPTH(DEPTH_A), .RD_LAT(1), .CLR_VAL(CLR_A)
  ) dut_a (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_a),
    .dbg_state(state_a), .bus(if_a.slave)
  );

  data_mem_ctl #(
    .W(W), .A(A), .DEPTH(DEPTH_B), .RD_LAT(0), .CLR_VAL(CLR_B)
  ) dut_b (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_b),
    .dbg_state(state_b), .bus(if_b.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model and scoreboard
  logic [W-1:0] mem_a [DEPTH_A];
  logic [W-1:0] mem_b [DEPTH_B];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] last_a;
  logic         pend_err_a;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                         input logic [3:0] s);
    logic [W-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH_A; i++) mem_a[i] = CLR_A;
    for (int i = 0; i < DEPTH_B; i++) mem_b[i] = CLR_B;
  endtask

  // A's response to whatever was accepted on the previous edge.
  task automatic check_a();
    check("rvalid_a", if_a.rdata_valid, (exp_q.size() > 0));
    if (exp_q.size() > 0) last_a = exp_q.pop_front();
    check("rdata_a", if_a.rdata, last_a);
    check("err_a", if_a.err, pend_err_a);
    pend_err_a = 1'b0;
  endtask

  // driver tasks: entered and left at posedge + 1
  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    clr_req   = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    pend_err_a = 1'b0;
    last_a     = '0;
    check("rst_busy_a", busy_a, 1);
    check("rst_busy_b", busy_b, 1);
    check("rst_ready_a", if_a.req_ready, 0);
    check("rst_ready_b", if_b.req_ready, 0);
    check("rst_rdata_a", if_a.rdata, 0);
    check("rst_rvalid_a", if_a.rdata_valid, 0);
    check("rst_err_a", if_a.err, 0);
    check("rst_state_a", state_a, CLEAR);
    reset = 1'b0;
  endtask

  task automatic wait_sweep(input bit poke);
    req_valid = 1'b0;
    clr_req   = 1'b0;
    for (int i = 0; i <= DEPTH_B; i++) begin
      @(negedge clk);
      check_a();
      check("rvalid_b_clr", if_b.rdata_valid, 0);
      check("busy_a_clr", busy_a, (i < DEPTH_A));
      check("ready_a_clr", if_a.req_ready, (i >= DEPTH_A));
      check("busy_b_clr", busy_b, (i < DEPTH_B));
      check("ready_b_clr", if_b.req_ready, (i >= DEPTH_B));
      clr_req = poke && (i == 50);
    end
    clear_model();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic wr, input logic [A-1:0] a,
                      input logic [W-1:0] d, input logic [3:0] s, input logic clr);
    req_valid = v;
    req_write = wr;
    addr      = a;
    wdata     = d;
    wstrb     = s;
    clr_req   = clr;
    @(negedge clk);
    check("ready_a", if_a.req_ready, 1);
    check("ready_b", if_b.req_ready, 1);
    check("busy_a", busy_a, 0);
    check("state_b", state_b, READY);
    check_a();
    check("rvalid_b", if_b.rdata_valid, (v && !wr));
    check("rdata_b", if_b.rdata, (v && !wr) ? mem_b[a] : '0);
    check("err_b", if_b.err, 0);
    if (v) begin
      if (!wr) exp_q.push_back((a < DEPTH_A) ? mem_a[a] : '0);
      pend_err_a = (a >= DEPTH_A);
      if (wr) begin
        if (a < DEPTH_A) mem_a[a] = merge(mem_a[a], d, s);
        mem_b[a] = merge(mem_b[a], d, s);
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    clr_req   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic         v;
    logic         wr;
    logic         clr;
    logic [A-1:0] a;

    reset = 1'b1; clr_req = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    addr = '0; wdata = '0; wstrb = '0; last_a = '0; pend_err_a = 1'b0;

    // reset, then reset again 100 cycles into the sweep; clr_req mid-sweep is ignored
    do_reset();
    repeat (100) begin
      @(negedge clk);
      check("busy_mid_a", busy_a, 1);
      check("busy_mid_b", busy_b, 1);
    end
    @(posedge clk);
    #1;
    do_reset();
    wait_sweep(1'b1);

    // full readback after clear, including A's out-of-range tail
    for (int i = 0; i < DEPTH_B; i++) step(1'b1, 1'b0, 8'(i), '0, 4'h0, 1'b0);

    // byte-lane merge
    step(1'b1, 1'b1, 8'd5, 32'h1122_3344, 4'hF, 1'b0);
    step(1'b1, 1'b1, 8'd5, 32'hAABB_CCDD, 4'b0101, 1'b0);
    step(1'b1, 1'b0, 8'd5, '0, 4'h0, 1'b0);

    // store then load next cycle
    step(1'b1, 1'b1, 8'd3, 32'h0000_005A, 4'h1, 1'b0);
    step(1'b1, 1'b0, 8'd3, '0, 4'h0, 1'b0);

    // out of range on A: store dropped, load returns zero, aliasing entry untouched
    step(1'b1, 1'b1, 8'd10, 32'hCAFE_0010, 4'hF, 1'b0);
    step(1'b1, 1'b1, 8'd210, 32'h1234_5678, 4'hF, 1'b0);
    step(1'b1, 1'b0, 8'd210, '0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 8'd10, '0, 4'h0, 1'b0);

    // clr_req together with a load completes the load, then sweeps
    step(1'b1, 1'b1, 8'd7, 32'h0000_0042, 4'hF, 1'b0);
    step(1'b1, 1'b0, 8'd7, '0, 4'h0, 1'b1);
    wait_sweep(1'b0);
    step(1'b1, 1'b0, 8'd7, '0, 4'h0, 1'b0);

    // randomized traffic on a small hot window plus A's out-of-range region
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      wr  = $urandom_range(0, 1) != 0;
      a   = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(DEPTH_A, 255))
                                        : 8'($urandom_range(0, 15));
      clr = ($urandom_range(0, 79) == 0);
      step(v, wr, a, $urandom, 4'($urandom_range(0, 15)), clr);
      if (clr) wait_sweep(1'b0);
    end
    step(1'b0, 1'b0, '0, '0, 4'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
